// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-stage controller.
//   state_t    : controller FSM encoding
//   WORD_LSB   : number of byte-offset bits dropped for word accesses
//   word_addr  : returns a byte address with its byte-offset bits cleared
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WDRAIN = 2'd1,
      RREQ   = 2'd2,
      RRESP  = 2'd3
   } state_t;

   localparam int WORD_LSB = 2;
   localparam int PKG_AW   = 32;

   function automatic logic [PKG_AW-1:0] word_addr(input logic [PKG_AW-1:0] addr);
      return {addr[PKG_AW-1:WORD_LSB], {WORD_LSB{1'b0}}};
   endfunction

endpackage

// File: rtl/mem_stage_ctrl_store_buf.sv
// One-entry posted store buffer.
//   clk, rst_n    : clock, async active-low reset
//   capture       : load the entry with addr_word/data_in (wins over clear)
//   clear         : invalidate the entry (its drain write was acknowledged)
//   addr_word     : word address of the store being captured
//   data_in       : store data
//   lookup_word   : word address of the current load, for forwarding
//   sb_valid      : entry holds an undrained store
//   sb_hit        : entry valid and its address matches lookup_word
//   sb_addr       : buffered word address
//   sb_data       : buffered store data
module store_buf
   import mem_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   capture,
   input  logic                   clear,
   input  logic [AW-WORD_LSB-1:0] addr_word,
   input  logic [DW-1:0]          data_in,
   input  logic [AW-WORD_LSB-1:0] lookup_word,
   output logic                   sb_valid,
   output logic                   sb_hit,
   output logic [AW-WORD_LSB-1:0] sb_addr,
   output logic [DW-1:0]          sb_data
);

   // A capture in the same cycle the old entry drains re-fills the buffer,
   // so capture takes priority over clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_valid <= 1'b0;
         sb_addr  <= '0;
         sb_data  <= '0;
      end else if (capture) begin
         sb_valid <= 1'b1;
         sb_addr  <= addr_word;
         sb_data  <= data_in;
      end else if (clear) begin
         sb_valid <= 1'b0;
      end
   end

   assign sb_hit = sb_valid && (sb_addr == lookup_word);

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: sits between the pipeline M stage and a
// multi-cycle data-memory bus. Stores retire into a one-entry posted buffer
// that drains in the background; loads hitting the buffer are forwarded,
// loads missing it wait for the buffer to drain and then read the bus.
//
//   state  | meaning
//   IDLE   | no bus transaction; start drain if sb valid, else issue read on miss
//   WDRAIN | buffered store being written on the bus
//   RREQ   | load read outstanding (bus_req raised here if it dropped after a drain)
//   RRESP  | read data in rdata_q handed to the pipeline, stall released
//
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   memreadM, memwriteM   : M-stage load / store (store wins if both)
//   addrM, wdataM         : M-stage byte address and store data
//   readdataM             : load result, valid with memreadM=1 and stallM=0
//   stallM                : freeze the pipeline this cycle
//   bus_req/we/addr/wdata : registered bus request, held until acked
//   bus_rdata, bus_ack    : read data and single-cycle completion strobe
module mem_stage_ctrl
   import mem_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          memreadM,
   input  logic          memwriteM,
   input  logic [AW-1:0] addrM,
   input  logic [DW-1:0] wdataM,
   output logic [DW-1:0] readdataM,
   output logic          stallM,
   output logic          bus_req,
   output logic          bus_we,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_wdata,
   input  logic [DW-1:0] bus_rdata,
   input  logic          bus_ack
);

   state_t state, state_nxt;

   logic                   is_store, is_load, load_miss;
   logic                   ack_v, drain_ack;
   logic                   sb_capture;
   logic                   sb_valid, sb_hit;
   logic [AW-WORD_LSB-1:0] sb_addr;
   logic [DW-1:0]          sb_data;
   logic [DW-1:0]          rdata_q;
   logic [AW-1:0]          addr_aligned;

   assign is_store     = memwriteM;
   assign is_load      = memreadM && !memwriteM;
   assign load_miss    = is_load && !sb_hit;
   assign ack_v        = bus_req && bus_ack;
   assign drain_ack    = (state == WDRAIN) && ack_v;
   assign addr_aligned = word_addr(addrM);

   store_buf #(.AW(AW), .DW(DW)) u_sb (
      .clk         (clk),
      .rst_n       (rst_n),
      .capture     (sb_capture),
      .clear       (drain_ack),
      .addr_word   (addrM[AW-1:WORD_LSB]),
      .data_in     (wdataM),
      .lookup_word (addrM[AW-1:WORD_LSB]),
      .sb_valid    (sb_valid),
      .sb_hit      (sb_hit),
      .sb_addr     (sb_addr),
      .sb_data     (sb_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (sb_valid)       state_nxt = WDRAIN;
            else if (load_miss) state_nxt = RREQ;
         end
         WDRAIN: begin
            if (ack_v) state_nxt = load_miss ? RREQ : IDLE;
         end
         RREQ: begin
            if (ack_v) state_nxt = RRESP;
         end
         RRESP:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The load sitting in M during RRESP is the one being completed, so it
   // must not count as a miss again. stallM is forced low while in reset.
   always_comb begin
      stallM     = 1'b0;
      readdataM  = '0;
      sb_capture = 1'b0;
      if (is_store) begin
         stallM = sb_valid && !drain_ack;
      end else if (load_miss && state != RRESP) begin
         stallM = 1'b1;
      end
      if (!rst_n) stallM = 1'b0;
      sb_capture = is_store && !stallM;
      if (is_load && sb_hit)  readdataM = sb_data;
      else if (state == RRESP) readdataM = rdata_q;
   end

   // Bus request registers. After a drain ack, bus_req drops for a cycle even
   // if a read follows; RREQ re-raises it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         rdata_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sb_valid) begin
                  bus_req   <= 1'b1;
                  bus_we    <= 1'b1;
                  bus_addr  <= {sb_addr, {WORD_LSB{1'b0}}};
                  bus_wdata <= sb_data;
               end else if (load_miss) begin
                  bus_req  <= 1'b1;
                  bus_we   <= 1'b0;
                  bus_addr <= addr_aligned;
               end
            end
            WDRAIN: begin
               if (ack_v) begin
                  bus_req <= 1'b0;
                  bus_we  <= 1'b0;
               end
            end
            RREQ: begin
               if (!bus_req) begin
                  bus_req  <= 1'b1;
                  bus_we   <= 1'b0;
                  bus_addr <= addr_aligned;
               end else if (bus_ack) begin
                  bus_req <= 1'b0;
                  rdata_q <= bus_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        memreadM, memwriteM;
   logic [31:0] addrM, wdataM;
   logic [31:0] readdataM;
   logic        stallM;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   int errors = 0;
   int checks = 0;

   mem_stage_ctrl #(.AW(32), .DW(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .memreadM  (memreadM),
      .memwriteM (memwriteM),
      .addrM     (addrM),
      .wdataM    (wdataM),
      .readdataM (readdataM),
      .stallM    (stallM),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_ack   (bus_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle's inputs at the falling edge, then settle before checks.
   task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic ack, input logic [31:0] rdat);
      @(negedge clk);
      memreadM  = rd;
      memwriteM = wr;
      addrM     = a;
      wdataM    = wd;
      bus_ack   = ack;
      bus_rdata = rdat;
      #1;
   endtask

   initial begin
      rst_n = 1'b0; memreadM = 0; memwriteM = 0; addrM = 0; wdataM = 0;
      bus_ack = 0; bus_rdata = 0;
      #12;
      chk("rst_req",   32'(bus_req), 0);
      chk("rst_we",    32'(bus_we), 0);
      chk("rst_stall", 32'(stallM), 0);
      chk("rst_rdata", readdataM, 0);
      chk("rst_addr",  bus_addr, 0);
      chk("rst_wdata", bus_wdata, 0);
      @(negedge clk); rst_n = 1'b1;

      // Store 0x100 with ack after 3 request cycles
      drive(0, 1, 32'h100, 32'hDEADBEEF, 0, 0);
      chk("t1_store_stall", 32'(stallM), 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("t1_sbv_set", 32'(dut.sb_valid), 1);
      chk("t1_req_c1", 32'(bus_req), 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("t1_req_c2", 32'(bus_req), 1);
      chk("t1_we_c2", 32'(bus_we), 1);
      chk("t1_addr_c2", bus_addr, 32'h100);
      chk("t1_wdata_c2", bus_wdata, 32'hDEADBEEF);
      drive(0, 0, 0, 0, 0, 0);
      chk("t1_req_c3", 32'(bus_req), 1);
      chk("t1_addr_c3", bus_addr, 32'h100);
      drive(0, 0, 0, 0, 1, 0);
      chk("t1_req_c4", 32'(bus_req), 1);
      chk("t1_addr_c4", bus_addr, 32'h100);
      drive(0, 0, 0, 0, 0, 0);
      chk("t1_req_drop", 32'(bus_req), 0);
      chk("t1_sbv_clr", 32'(dut.sb_valid), 0);

      // Store 0x200 then load 0x202 hits the buffer
      drive(0, 1, 32'h200, 32'h11, 0, 0);
      chk("t2_store_stall", 32'(stallM), 0);
      drive(1, 0, 32'h202, 0, 0, 0);
      chk("t2_hit_stall", 32'(stallM), 0);
      chk("t2_hit_data", readdataM, 32'h11);
      chk("t2_no_req", 32'(bus_req), 0);
      drive(0, 0, 0, 0, 1, 0);
      chk("t2_drain_req", 32'(bus_req), 1);
      chk("t2_drain_we", 32'(bus_we), 1);
      chk("t2_drain_addr", bus_addr, 32'h200);
      drive(0, 0, 0, 0, 0, 0);
      chk("t2_req_drop", 32'(bus_req), 0);
      chk("t2_sbv_clr", 32'(dut.sb_valid), 0);
      chk("t2_idle_rdata", readdataM, 0);

      // Load miss 0x300, immediate ack
      drive(1, 0, 32'h300, 0, 0, 0);
      chk("t3_stall_c0", 32'(stallM), 1);
      chk("t3_rdata_c0", readdataM, 0);
      drive(1, 0, 32'h300, 0, 1, 32'hCAFE);
      chk("t3_stall_c1", 32'(stallM), 1);
      chk("t3_req_c1", 32'(bus_req), 1);
      chk("t3_we_c1", 32'(bus_we), 0);
      chk("t3_addr_c1", bus_addr, 32'h300);
      drive(1, 0, 32'h300, 0, 0, 0);
      chk("t3_stall_c2", 32'(stallM), 0);
      chk("t3_rdata_c2", readdataM, 32'hCAFE);
      chk("t3_req_c2", 32'(bus_req), 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("t3_rdata_idle", readdataM, 0);
      chk("t3_state_idle", 32'(dut.state), 32'(IDLE));

      // Store A while empty, store B stalls until A's drain ack
      drive(0, 1, 32'h10, 32'hA, 0, 0);
      chk("t4_a_stall", 32'(stallM), 0);
      drive(0, 1, 32'h14, 32'hB, 0, 0);
      chk("t4_b_stall_c1", 32'(stallM), 1);
      drive(0, 1, 32'h14, 32'hB, 0, 0);
      chk("t4_b_stall_c2", 32'(stallM), 1);
      chk("t4_a_addr", bus_addr, 32'h10);
      chk("t4_a_wdata", bus_wdata, 32'hA);
      drive(0, 1, 32'h14, 32'hB, 1, 0);
      chk("t4_b_stall_ack", 32'(stallM), 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("t4_req_gap", 32'(bus_req), 0);
      chk("t4_sbv_refill", 32'(dut.sb_valid), 1);
      drive(0, 0, 0, 0, 1, 0);
      chk("t4_b_req", 32'(bus_req), 1);
      chk("t4_b_we", 32'(bus_we), 1);
      chk("t4_b_addr", bus_addr, 32'h14);
      chk("t4_b_wdata", bus_wdata, 32'hB);
      drive(0, 0, 0, 0, 0, 0);
      chk("t4_sbv_clr", 32'(dut.sb_valid), 0);
      chk("t4_req_drop", 32'(bus_req), 0);

      // Store 0x40 then load miss 0x80: write completes before read issued
      drive(0, 1, 32'h40, 32'h40404040, 0, 0);
      chk("t5_store_stall", 32'(stallM), 0);
      drive(1, 0, 32'h80, 0, 0, 0);
      chk("t5_stall_c1", 32'(stallM), 1);
      chk("t5_req_c1", 32'(bus_req), 0);
      drive(1, 0, 32'h80, 0, 1, 0);
      chk("t5_stall_c2", 32'(stallM), 1);
      chk("t5_w_we", 32'(bus_we), 1);
      chk("t5_w_addr", bus_addr, 32'h40);
      drive(1, 0, 32'h80, 0, 0, 0);
      chk("t5_stall_c3", 32'(stallM), 1);
      chk("t5_req_gap", 32'(bus_req), 0);
      drive(1, 0, 32'h80, 0, 1, 32'h12345678);
      chk("t5_stall_c4", 32'(stallM), 1);
      chk("t5_r_req", 32'(bus_req), 1);
      chk("t5_r_we", 32'(bus_we), 0);
      chk("t5_r_addr", bus_addr, 32'h80);
      drive(1, 0, 32'h80, 0, 0, 0);
      chk("t5_stall_c5", 32'(stallM), 0);
      chk("t5_rdata", readdataM, 32'h12345678);
      drive(0, 0, 0, 0, 0, 0);

      // Reset asserted mid-RREQ
      drive(1, 0, 32'hA00, 0, 0, 0);
      chk("t6_stall_c0", 32'(stallM), 1);
      drive(1, 0, 32'hA00, 0, 0, 0);
      chk("t6_req_rreq", 32'(bus_req), 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_req", 32'(bus_req), 0);
      chk("t6_rst_stall", 32'(stallM), 0);
      chk("t6_rst_addr", bus_addr, 0);
      drive(0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      chk("t6_state", 32'(dut.state), 32'(IDLE));
      chk("t6_sbv", 32'(dut.sb_valid), 0);
      chk("t6_req", 32'(bus_req), 0);
      chk("t6_stall", 32'(stallM), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller between the pipeline's M stage and a multi-cycle external data-memory bus.
- Consumes the M-stage address and store data from the E/M register. Produces readdataM for the M/W register.
- Raises stallM whenever the access cannot complete in the current cycle.
- Holds a one-entry posted store buffer so stores normally retire without stalling; loads that hit the buffer are forwarded.

Parameters:
AW, 32, byte-address width
DW, 32, data width; word accesses only

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (reset=0 clears all state)
memreadM  in  1  M-stage load
memwriteM  in  1  M-stage store; takes priority if both set
addrM  in  AW  byte address (aluout); bits [1:0] ignored
wdataM  in  DW  store data (writedataM)
readdataM  out  DW  load result, valid when memreadM=1 and stallM=0
stallM  out  1  freeze F/D/E/M and bubble W this cycle
bus_req  out  1  bus request
bus_we  out  1  1=write, 0=read
bus_addr  out  AW  {addr[AW-1:2],2'b00}
bus_wdata  out  DW  write data
bus_rdata  in  DW  read data, valid with bus_ack
bus_ack  in  1  single-cycle completion strobe

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, sb_valid=0, bus_req=0, bus_we=0.
  - bus_addr, bus_wdata, rdata_q and readdataM all =0; stallM=0.
  - An in-flight bus transaction is abandoned; no ack is expected afterwards.
- Bus handshake:
  - bus_req, bus_we, bus_addr and bus_wdata are registered.
  - They are held stable from assertion until the cycle bus_ack=1 is sampled.
  - bus_req drops in the cycle after ack. One outstanding transaction at most.
  - bus_ack while bus_req=0 is ignored.
- Store buffer (sb): fields {sb_valid, sb_addr[AW-1:2], sb_data}.
- FSM states: IDLE, WDRAIN, RREQ, RRESP.
  - IDLE: if sb_valid, go to WDRAIN, drive bus_req=1, bus_we=1 from sb. Else if a load misses, go to RREQ, drive bus_req=1, bus_we=0, bus_addr=addrM.
  - WDRAIN: on bus_ack, sb_valid clears (unless re-filled the same cycle). Then go to RREQ if a load miss is pending, else IDLE.
  - RREQ: on bus_ack, rdata_q<=bus_rdata and go to RRESP.
  - RRESP: stallM=0, readdataM=rdata_q. Return to IDLE next cycle.
- Stores:
  - Captured into sb in any cycle where memwriteM=1 and stallM=0.
  - stallM=0 for a store if sb is empty, or if sb is draining and bus_ack=1 this cycle (free and re-fill in the same cycle).
  - Otherwise stallM=1.
  - Best case: a store costs 0 stall cycles.
- Loads:
  - Hit (sb_valid and sb_addr==addrM[AW-1:2]): readdataM=sb_data combinationally, stallM=0, no bus access. This holds even while sb is draining.
  - Miss: stallM=1 until RRESP. The sb drains first (program order), then the read is issued.
  - Minimum miss latency with empty sb and ack in the first req cycle: stall for 2 cycles, data returned in the 3rd.
- The pipeline holds memreadM, memwriteM, addrM and wdataM stable while stallM=1. The block relies on this and must not re-issue a completed load in RRESP.
- stallM is combinational from state, sb_valid, the address compare and bus_ack. It has no combinational path from bus_rdata.
- With no memory op in M, stallM=0 and the sb drains in the background.
- readdataM=0 when no load is completing.

Decomposition:
- Package mem_pkg:
  - state enum {IDLE, WDRAIN, RREQ, RRESP}
  - localparam WORD_LSB=2
  - a word_addr helper function
- Sub-module store_buf:
  - holds the one-entry sb
  - capture/clear controls
  - combinational hit compare; outputs sb_valid, sb_hit, sb_addr, sb_data
- mem_stage_ctrl contains the FSM and bus registers.

Test Plan:
- Store to 0x100 data 0xDEADBEEF with bus_ack after 3 req cycles -> stallM=0 in the store cycle; bus_req=1, bus_we=1, bus_addr=0x100 held 3 cycles; sb_valid clears after ack.
- Store 0x200=0x11, then load 0x202 next cycle -> hit forward, readdataM=0x11, stallM=0, no read on bus.
- Load 0x300 with sb empty, ack immediately, bus_rdata=0xCAFE -> stallM=1 for 2 cycles, then readdataM=0xCAFE with stallM=0.
- Store A (0x10), then store B (0x14) while A is draining with ack 2 cycles later -> B stalls until the ack cycle, then is captured; the bus sees A then B in order.
- Store 0x40, then load miss 0x80 -> the write to 0x40 completes before the read to 0x80 is requested; stallM=1 throughout the load.
- Assert reset=0 mid-RREQ -> bus_req=0 and stallM=0 immediately; after release the FSM is IDLE and sb_valid=0.
